debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Input conditioning stage that sits directly upstream of the d_ff storage element.
- Takes a raw asynchronous, bouncy input (push-button or switch) and synchronises it into the clk domain.
- Rejects glitches shorter than a programmable window.
- Produces a clean level (dout / dout_bar) that drives the flip-flop D input, plus single-cycle rise/fall strobes for downstream counters and FSMs.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal 2..4).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a new level (legal ≥2).
- CNT_W, 16, width of the debounce/hold counter; requires DEBOUNCE_CYCLES ≤ 2^CNT_W and HOLD_CYCLES ≤ 2^CNT_W.
- HOLD_CYCLES, 16, long-press threshold in cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous input.
- dout  output  1  debounced level.
- dout_bar  output  1  always the complement of dout.
- rise  output  1  one-cycle pulse when dout goes 0→1.
- fall  output  1  one-cycle pulse when dout goes 1→0.
- long_press  output  1  one-cycle pulse on a long hold (optional feature).

Behaviour:
- Reset values: synchroniser flops 0, state STABLE_LOW, counter 0, dout=0, dout_bar=1, rise=0, fall=0, long_press=0.
- Reset is sampled only on the clk edge; asserting it mid-WAIT aborts the pending transition with no strobe.
- Synchroniser: chain of SYNC_STAGES flops; din_s is the last stage. The FSM sees only din_s, never din.
- State STABLE_LOW: on din_s=1, go to WAIT_HIGH and clear the counter.
- State WAIT_HIGH:
  - din_s=0 → return to STABLE_LOW; glitch rejected, no output change.
  - din_s=1 and count=DEBOUNCE_CYCLES-1 → go to STABLE_HIGH, dout←1, rise←1 for one cycle.
  - Otherwise count++.
- STABLE_HIGH and WAIT_LOW: mirror of the above with polarity swapped; fall pulses on acceptance.
- Latency: din changes before edge E and stays stable → dout updates at edge E+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults give edge E+6.
- Acceptance window (aligned to edges):
  - A pulse ≥ DEBOUNCE_CYCLES+1 cycles wide is accepted.
  - A pulse ≤ DEBOUNCE_CYCLES cycles wide is rejected.
- Strobe timing: rise and fall are registered and coincide with the dout update cycle. They never assert together and never without a dout change.
- dout_bar is derived combinationally as ~dout, so it never disagrees with dout in any cycle.
- Counter never wraps; it is cleared on every state entry.
- Continuous bouncing keeps the FSM cycling between STABLE and WAIT with outputs frozen.

Optional Feature:
- Macro: DEBOUNCE_LONGPRESS_EN.
- Defined:
  - In STABLE_HIGH, a hold counter increments each cycle.
  - When it reaches HOLD_CYCLES-1, long_press pulses for one cycle and the counter saturates, giving one pulse per press.
  - Entering WAIT_LOW does not clear the hold counter; it clears on re-entry to STABLE_HIGH from WAIT_HIGH and on reset.
  - A bounce that returns WAIT_LOW to STABLE_HIGH resumes counting.
- Undefined: the long_press port still exists, tied to 0; no hold logic is instantiated.

Test Plan:
- Reset check: reset=1 for 2 cycles with din=1 → dout=0, dout_bar=1, rise=fall=long_press=0. After release with din still 1, rise is seen 6 edges later.
- Clean rise (defaults): din 0→1 before edge E, held → dout=1, dout_bar=0 and rise=1 exactly at edge E+6, for one cycle only. Then fall=1 exactly 6 edges after din returns to 0.
- Glitch rejection: din high for exactly 4 cycles, then low → dout stays 0, rise never asserts. A 5-cycle pulse → dout=1 and rise asserted once.
- Bounce: din toggles every cycle for 20 cycles, then holds 1 → no strobes during toggling. A single rise arrives 6 edges after the final stable sample.
- Mid-operation reset: reset asserted while in WAIT_HIGH (2 cycles after din rises) → no rise, dout=0. Debounce restarts from scratch after reset release.
- With DEBOUNCE_LONGPRESS_EN, HOLD_CYCLES=16: hold din high for 40 cycles → exactly one long_press pulse, 16 cycles after rise. Without the macro → long_press stays 0 throughout.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronise and debounce a raw bouncy input into a clean level plus rise/fall strobes.
// Optional long-press pulse enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic dout_bar,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam bit ParamsOk = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                              (DEBOUNCE_CYCLES >= 2) && (HOLD_CYCLES >= 1) &&
                              (longint'(DEBOUNCE_CYCLES) <= (64'd1 << CNT_W)) &&
                              (longint'(HOLD_CYCLES) <= (64'd1 << CNT_W));

    // Illegal configurations leave an empty marker scope in the hierarchy.
    if (!ParamsOk) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        StStableLow,
        StWaitHigh,
        StStableHigh,
        StWaitLow
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   din_s;
    logic                   cnt_done;

    assign din_s    = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= StStableLow;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StStableLow: begin
                if (din_s) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!din_s) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStableHigh: begin
                if (!din_s) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (din_s) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StStableLow;
        endcase
    end

    assign dout     = dout_q;
    assign dout_bar = ~dout_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [CNT_W:0] HoldLast = (CNT_W + 1)'(HOLD_CYCLES - 1);

    // One extra bit lets the counter park at HOLD_CYCLES, giving one pulse per press.
    logic [CNT_W:0] hold_q, hold_d;
    logic           lp_q, lp_d;

    always_comb begin
        hold_d = hold_q;
        lp_d   = 1'b0;
        if (state_q == StWaitHigh && state_d == StStableHigh) begin
            hold_d = '0;
        end else if (state_q == StStableHigh && hold_q <= HoldLast) begin
            hold_d = hold_q + (CNT_W + 1)'(1);
            lp_d   = (hold_q == HoldLast);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            lp_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            lp_q   <= lp_d;
        end
    end

    assign long_press = lp_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync at default parameters.
// Long-press expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic dout;
    logic dout_bar;
    logic rise;
    logic fall;
    logic long_press;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    always #5 clk = ~clk;

    debounce_sync dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .dout_bar   (dout_bar),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // After wait_edges(n) with inputs set before edge E, we sit 1ns past edge E+n-1.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic d, input logic r, input logic f);
        check({tag, "_dout"}, dout, d);
        check({tag, "_dout_bar"}, dout_bar, ~d);
        check({tag, "_rise"}, rise, r);
        check({tag, "_fall"}, fall, f);
    endtask

    // Drive a held level and expect the strobe exactly 6 edges later, lasting one cycle.
    task automatic run_transition(input string tag, input logic lvl);
        din = lvl;
        wait_edges(6);
        expect_outs({tag, "_e5"}, ~lvl, 1'b0, 1'b0);
        wait_edges(1);
        expect_outs({tag, "_e6"}, lvl, lvl, ~lvl);
        wait_edges(1);
        expect_outs({tag, "_e7"}, lvl, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b1;
        wait_edges(2);
        expect_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset_long_press", long_press, 1'b0);
        reset = 1'b0;

        run_transition("reset_release", 1'b1);
        run_transition("fall_after_reset", 1'b0);
        run_transition("clean_rise", 1'b1);
        run_transition("clean_fall", 1'b0);

        // 4-cycle pulse must be rejected.
        din = 1'b1;
        wait_edges(4);
        din = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            expect_outs("glitch4", 1'b0, 1'b0, 1'b0);
        end

        // 5-cycle pulse is accepted; fall follows from the trailing edge.
        din = 1'b1;
        wait_edges(5);
        din = 1'b0;
        wait_edges(1);
        expect_outs("pulse5_e5", 1'b0, 1'b0, 1'b0);
        wait_edges(1);
        expect_outs("pulse5_e6", 1'b1, 1'b1, 1'b0);
        wait_edges(1);
        expect_outs("pulse5_e7", 1'b1, 1'b0, 1'b0);
        wait_edges(3);
        expect_outs("pulse5_e10", 1'b1, 1'b0, 1'b0);
        wait_edges(1);
        expect_outs("pulse5_e11", 1'b0, 1'b0, 1'b1);
        wait_edges(1);
        expect_outs("pulse5_e12", 1'b0, 1'b0, 1'b0);

        // Toggle every cycle: outputs frozen.
        for (int i = 0; i < 20; i++) begin
            din = ~din;
            wait_edges(1);
            expect_outs("bounce", 1'b0, 1'b0, 1'b0);
        end
        run_transition("bounce_settle", 1'b1);
        run_transition("bounce_release", 1'b0);

        // Reset while in WAIT_HIGH aborts the pending rise; debounce restarts afterwards.
        din = 1'b1;
        wait_edges(3);
        reset = 1'b1;
        wait_edges(1);
        expect_outs("midreset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_edges(1);
            expect_outs("midreset_restart", 1'b0, 1'b0, 1'b0);
        end
        wait_edges(1);
        expect_outs("midreset_rise", 1'b1, 1'b1, 1'b0);

        // Hold high 40 cycles after the rise.
        for (int i = 1; i <= 40; i++) begin
            wait_edges(1);
`ifdef DEBOUNCE_LONGPRESS_EN
            check("long_press", long_press, (i == 16));
`else
            check("long_press", long_press, 1'b0);
`endif
            check("hold_dout", dout, 1'b1);
            check("hold_rise", rise, 1'b0);
        end

        run_transition("final_fall", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
